// File: rtl/arp_recv.sv
// Receive-side ARP parser: byte-wide MAC stream in, decoded ARP fields out.
// Latency: o_valid/o_crc_err/o_drop register 2 clocks after i_rx_dv falls (abort/filter drop: 1 clock).
// Backpressure: none; every byte is consumed as it arrives, frames arriving while busy are absorbed.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_data, i_rx_dv       received byte and frame-valid (high across preamble..FCS)
//   i_my_mac              local MAC, compared on the last destination-MAC byte
//   o_src_mac, o_operation, o_SHA, o_SPA, o_THA, o_TPA
//                         fields of the last accepted frame (updated only with o_valid)
//   o_valid, o_crc_err, o_drop
//                         one-cycle verdict pulses, exactly one per frame reaching DST_MAC
`timescale 1ns/1ps
module arp_recv #(
    parameter logic [15:0] ARP_HTYPE       = 16'h0001,
    parameter logic [15:0] ARP_PTYPE       = 16'h0800,
    parameter logic [7:0]  ARP_HLEN        = 8'h06,
    parameter logic [7:0]  ARP_PLEN        = 8'h04,
    parameter int unsigned MIN_FRAME_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_data,
    input  logic        i_rx_dv,
    input  logic [47:0] i_my_mac,
    output logic [47:0] o_src_mac,
    output logic [1:0]  o_operation,
    output logic [47:0] o_SHA,
    output logic [31:0] o_SPA,
    output logic [47:0] o_THA,
    output logic [31:0] o_TPA,
    output logic        o_valid,
    output logic        o_crc_err,
    output logic        o_drop
);

    localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME_BYTES);
    localparam logic [61:0] HDR_FIXED   = {ARP_HTYPE, ARP_PTYPE, ARP_HLEN, ARP_PLEN, 14'd0};
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [3:0] {
        S_IDLE, S_PREAMBLE, S_DST_MAC, S_SRC_MAC, S_ETHER_TYPE, S_ARP_HDR,
        S_SHA, S_SPA, S_THA, S_TPA, S_PAD, S_CHECK, S_DROP
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic [15:0] len;
    logic [31:0] crc;
    logic [39:0] dst_sh;
    logic [47:0] src_sh;
    logic [7:0]  et_sh;
    logic [55:0] hdr_sh;
    logic [47:0] sha_sh, tha_sh;
    logic [31:0] spa_sh, tpa_sh;
    logic        valid_nxt, crc_err_nxt, drop_nxt;

    // Complete field words as seen on the cycle their last byte is on i_data.
    logic [47:0] dst_word;
    logic [15:0] et_word;
    logic [63:0] hdr_word;
    logic        hdr_active;
    logic        in_frame;

    assign dst_word   = {dst_sh, i_data};
    assign et_word    = {et_sh, i_data};
    assign hdr_word   = {hdr_sh, i_data};
    assign hdr_active = state inside {S_DST_MAC, S_SRC_MAC, S_ETHER_TYPE, S_ARP_HDR,
                                      S_SHA, S_SPA, S_THA, S_TPA};
    assign in_frame   = hdr_active || (state == S_PAD);

    // Reflected CRC-32, one byte LSB first, no final inversion.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        valid_nxt   = 1'b0;
        crc_err_nxt = 1'b0;
        drop_nxt    = 1'b0;
        case (state)
            S_IDLE: if (i_rx_dv) state_nxt = (i_data == 8'h55) ? S_PREAMBLE : S_DROP;
            // A frame that dies inside the preamble never reached DST_MAC: back to IDLE silently.
            S_PREAMBLE: begin
                if (!i_rx_dv)              state_nxt = S_IDLE;
                else if (i_data == 8'hD5)  state_nxt = S_DST_MAC;
                else if (i_data != 8'h55)  state_nxt = S_DROP;
            end
            S_DST_MAC: if (i_rx_dv && cnt == 4'd6) begin
                if (dst_word == 48'hFFFF_FFFF_FFFF || dst_word == i_my_mac) begin
                    state_nxt = S_SRC_MAC;
                end else begin
                    state_nxt = S_DROP;
                    drop_nxt  = 1'b1;
                end
            end
            S_SRC_MAC: if (i_rx_dv && cnt == 4'd6) state_nxt = S_ETHER_TYPE;
            S_ETHER_TYPE: if (i_rx_dv && cnt == 4'd2) begin
                if (et_word == 16'h0806) begin
                    state_nxt = S_ARP_HDR;
                end else begin
                    state_nxt = S_DROP;
                    drop_nxt  = 1'b1;
                end
            end
            S_ARP_HDR: if (i_rx_dv && cnt == 4'd8) begin
                if (hdr_word[63:2] != HDR_FIXED || hdr_word[1:0] == 2'd0 || hdr_word[1:0] == 2'd3) begin
                    state_nxt = S_DROP;
                    drop_nxt  = 1'b1;
                end else begin
                    state_nxt = S_SHA;
                end
            end
            S_SHA: if (i_rx_dv && cnt == 4'd6) state_nxt = S_SPA;
            S_SPA: if (i_rx_dv && cnt == 4'd4) state_nxt = S_THA;
            S_THA: if (i_rx_dv && cnt == 4'd6) state_nxt = S_TPA;
            S_TPA: if (i_rx_dv && cnt == 4'd4) state_nxt = S_PAD;
            S_PAD: if (!i_rx_dv) state_nxt = S_CHECK;
            S_CHECK: begin
                state_nxt = S_IDLE;
                if (len < MIN_LEN)             drop_nxt    = 1'b1;
                else if (crc != CRC_RESIDUE)   crc_err_nxt = 1'b1;
                else                           valid_nxt   = 1'b1;
            end
            S_DROP: if (!i_rx_dv) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Loss of carrier before the ARP body is complete overrides everything above.
        if (hdr_active && !i_rx_dv) begin
            state_nxt = S_IDLE;
            drop_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            len         <= '0;
            crc         <= 32'hFFFF_FFFF;
            dst_sh      <= '0;
            src_sh      <= '0;
            et_sh       <= '0;
            hdr_sh      <= '0;
            sha_sh      <= '0;
            spa_sh      <= '0;
            tha_sh      <= '0;
            tpa_sh      <= '0;
            o_src_mac   <= '0;
            o_operation <= '0;
            o_SHA       <= '0;
            o_SPA       <= '0;
            o_THA       <= '0;
            o_TPA       <= '0;
            o_valid     <= 1'b0;
            o_crc_err   <= 1'b0;
            o_drop      <= 1'b0;
        end else begin
            if (state_nxt != state)          cnt <= 4'd1;
            else if (i_rx_dv && cnt != 4'hF) cnt <= cnt + 4'd1;

            if (state == S_PREAMBLE && i_rx_dv && i_data == 8'hD5) begin
                crc <= 32'hFFFF_FFFF;
                len <= '0;
            end else if (in_frame && i_rx_dv) begin
                crc <= crc_byte(crc, i_data);
                if (len != 16'hFFFF) len <= len + 16'd1;
            end

            if (i_rx_dv) begin
                case (state)
                    S_DST_MAC:    dst_sh <= {dst_sh[31:0], i_data};
                    S_SRC_MAC:    src_sh <= {src_sh[39:0], i_data};
                    S_ETHER_TYPE: et_sh  <= i_data;
                    S_ARP_HDR:    hdr_sh <= {hdr_sh[47:0], i_data};
                    S_SHA:        sha_sh <= {sha_sh[39:0], i_data};
                    S_SPA:        spa_sh <= {spa_sh[23:0], i_data};
                    S_THA:        tha_sh <= {tha_sh[39:0], i_data};
                    S_TPA:        tpa_sh <= {tpa_sh[23:0], i_data};
                    default: ;
                endcase
            end

            o_valid   <= valid_nxt;
            o_crc_err <= crc_err_nxt;
            o_drop    <= drop_nxt;
            if (valid_nxt) begin
                o_src_mac   <= src_sh;
                o_operation <= hdr_sh[1:0];
                o_SHA       <= sha_sh;
                o_SPA       <= spa_sh;
                o_THA       <= tha_sh;
                o_TPA       <= tpa_sh;
            end
        end
    end

endmodule

// File: tb/tb_arp_recv.sv
`timescale 1ns/1ps
module tb_arp_recv;

    localparam logic [47:0] MY_MAC = 48'h02AA_BBCC_DDEE;
    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  i_data = '0;
    logic        i_rx_dv = 1'b0;
    logic [47:0] i_my_mac = MY_MAC;
    logic [47:0] o_src_mac, o_SHA, o_THA;
    logic [31:0] o_SPA, o_TPA;
    logic [1:0]  o_operation;
    logic        o_valid, o_crc_err, o_drop;

    arp_recv dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_rx_dv(i_rx_dv), .i_my_mac(i_my_mac),
        .o_src_mac(o_src_mac), .o_operation(o_operation), .o_SHA(o_SHA), .o_SPA(o_SPA),
        .o_THA(o_THA), .o_TPA(o_TPA), .o_valid(o_valid), .o_crc_err(o_crc_err), .o_drop(o_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [47:0] dst, src;
        logic [15:0] et;
        logic [63:0] hdr;
        logic [47:0] sha;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
        int          pad;
        int          flip;
        int          abort_at;
    } frame_t;

    logic [7:0] frm[$];
    int tests = 0, fails = 0;
    int n_valid = 0, n_crc = 0, n_drop = 0;
    int valid_cyc = 0, drop_cyc = 0, low_cyc = 0;

    // Reference: fields of the most recently accepted frame (what outputs must hold).
    logic [47:0] last_src = '0, last_sha = '0, last_tha = '0;
    logic [31:0] last_spa = '0, last_tpa = '0;
    logic [1:0]  last_oper = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid)   begin n_valid++; valid_cyc = cyc; end
            if (o_crc_err) n_crc++;
            if (o_drop)    begin n_drop++; drop_cyc = cyc; end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] rand48();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[47:0];
    endfunction

    function automatic logic [63:0] mk_hdr(input logic [1:0] op);
        return {16'h0001, 16'h0800, 8'h06, 8'h04, 14'd0, op};
    endfunction

    function automatic frame_t good_frame();
        frame_t f;
        f.dst      = ($urandom_range(0, 1) != 0) ? BCAST : MY_MAC;
        f.src      = rand48();
        f.et       = 16'h0806;
        f.hdr      = mk_hdr(($urandom_range(0, 1) != 0) ? 2'd1 : 2'd2);
        f.sha      = rand48();
        f.spa      = $urandom();
        f.tha      = rand48();
        f.tpa      = $urandom();
        f.pad      = $urandom_range(18, 30);
        f.flip     = -1;
        f.abort_at = -1;
        return f;
    endfunction

    // Outcome from the frame-level rules: 0 accepted, 1 FCS error, 2 dropped.
    function automatic int predict(input frame_t f);
        if (f.abort_at >= 0 && f.abort_at < 42) return 2;
        if (f.dst != BCAST && f.dst != MY_MAC) return 2;
        if (f.et != 16'h0806) return 2;
        if (f.hdr[63:48] != 16'h0001 || f.hdr[47:32] != 16'h0800 ||
            f.hdr[31:24] != 8'h06 || f.hdr[23:16] != 8'h04 || f.hdr[15:2] != 14'd0) return 2;
        if (f.hdr[1:0] == 2'd0 || f.hdr[1:0] == 2'd3) return 2;
        if (42 + f.pad + 4 < 64) return 2;
        if (f.flip >= 0) return 1;
        return 0;
    endfunction

    task automatic push_be(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) frm.push_back(v[i*8 +: 8]);
    endtask

    task automatic build(input frame_t f);
        logic [31:0] c;
        frm.delete();
        push_be(64'(f.dst), 6);
        push_be(64'(f.src), 6);
        push_be(64'(f.et), 2);
        push_be(f.hdr, 8);
        push_be(64'(f.sha), 6);
        push_be(64'(f.spa), 4);
        push_be(64'(f.tha), 6);
        push_be(64'(f.tpa), 4);
        for (int i = 0; i < f.pad; i++) frm.push_back(8'($urandom_range(0, 255)));
        c = 32'hFFFF_FFFF;
        foreach (frm[k]) begin
            c = c ^ {24'd0, frm[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) frm.push_back(c[k*8 +: 8]);
        if (f.flip >= 0) frm[f.flip] = ~frm[f.flip];
    endtask

    task automatic drive(input logic [7:0] b);
        i_data  = b;
        i_rx_dv = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input int abort_at, input int gap);
        for (int i = 0; i < 7; i++) drive(8'h55);
        drive(8'hD5);
        for (int i = 0; i < frm.size(); i++) begin
            if (abort_at >= 0 && i >= abort_at) break;
            drive(frm[i]);
        end
        i_rx_dv = 1'b0;
        i_data  = '0;
        low_cyc = cyc;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_held(input string tag);
        check_val({tag, ".src"},  64'(o_src_mac),   64'(last_src));
        check_val({tag, ".oper"}, 64'(o_operation), 64'(last_oper));
        check_val({tag, ".sha"},  64'(o_SHA),       64'(last_sha));
        check_val({tag, ".spa"},  64'(o_SPA),       64'(last_spa));
        check_val({tag, ".tha"},  64'(o_THA),       64'(last_tha));
        check_val({tag, ".tpa"},  64'(o_TPA),       64'(last_tpa));
    endtask

    task automatic run_frame(input string tag, input frame_t f, input int gap);
        int v0, c0, d0, exp;
        build(f);
        v0 = n_valid; c0 = n_crc; d0 = n_drop;
        send(f.abort_at, gap);
        exp = predict(f);
        check_val({tag, ".n_valid"}, 64'(n_valid - v0), 64'(exp == 0));
        check_val({tag, ".n_crc"},   64'(n_crc - c0),   64'(exp == 1));
        check_val({tag, ".n_drop"},  64'(n_drop - d0),  64'(exp == 2));
        if (exp == 0) begin
            check_val({tag, ".valid_lat"}, 64'(valid_cyc - low_cyc), 64'd2);
            last_src  = f.src;  last_oper = f.hdr[1:0];
            last_sha  = f.sha;  last_spa  = f.spa;
            last_tha  = f.tha;  last_tpa  = f.tpa;
        end else if (exp == 2 && f.abort_at >= 0) begin
            check_val({tag, ".drop_lat"}, 64'(drop_cyc - low_cyc), 64'd1);
        end
        check_held(tag);
    endtask

    initial begin
        frame_t f, g;
        int v0, c0, d0, k;

        repeat (3) @(negedge clk);
        check_val("rst.valid",   64'(o_valid),   64'd0);
        check_val("rst.crc_err", 64'(o_crc_err), 64'd0);
        check_val("rst.drop",    64'(o_drop),    64'd0);
        check_held("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Broadcast request with the canonical addresses, minimum-size frame.
        f = good_frame();
        f.dst = BCAST; f.src = 48'h0011_2233_4455; f.sha = 48'h0011_2233_4455;
        f.spa = 32'hC0A8010A; f.tha = '0; f.tpa = 32'hC0A80102;
        f.hdr = mk_hdr(2'd1); f.pad = 18;
        run_frame("t1", f, 8);

        // Corrupted pad byte: FCS error, outputs held.
        g = f; g.flip = 42 + 5;
        run_frame("t2", g, 8);

        // Wrong EtherType, then foreign unicast destination, then a good frame.
        g = f; g.et = 16'h0800;
        run_frame("t3a", g, 8);
        g = f; g.dst = 48'h0200_0000_0099;
        run_frame("t3b", g, 8);
        run_frame("t3c", good_frame(), 8);

        // Carrier lost after 20 post-SFD bytes, then recovery.
        g = good_frame(); g.abort_at = 20;
        run_frame("t4a", g, 8);
        run_frame("t4b", good_frame(), 8);

        // Two unicast replies with a 12-cycle gap.
        for (int i = 0; i < 2; i++) begin
            g = good_frame(); g.dst = MY_MAC; g.hdr = mk_hdr(2'd2);
            run_frame($sformatf("t5_%0d", i), g, 12);
        end

        // Reset asserted while SHA bytes are streaming.
        g = good_frame(); g.dst = MY_MAC; g.hdr = mk_hdr(2'd2);
        build(g);
        v0 = n_valid; c0 = n_crc; d0 = n_drop;
        for (int i = 0; i < 7; i++) drive(8'h55);
        drive(8'hD5);
        for (int i = 0; i < 24; i++) drive(frm[i]);
        rst_n = 1'b0; i_rx_dv = 1'b0; i_data = '0;
        #1;
        last_src = '0; last_oper = '0; last_sha = '0; last_spa = '0; last_tha = '0; last_tpa = '0;
        check_held("t6_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("t6.pulses", 64'((n_valid - v0) + (n_crc - c0) + (n_drop - d0)), 64'd0);
        run_frame("t6b", g, 8);

        // Randomised mix of good and faulty frames.
        for (int i = 0; i < 40; i++) begin
            f = good_frame();
            k = $urandom_range(0, 7);
            case (k)
                1: f.flip = $urandom_range(22, 42 + f.pad + 3);
                2: f.dst = {16'h0200, $urandom()};
                3: f.et = 16'($urandom_range(0, 65535));
                4: f.hdr = mk_hdr(($urandom_range(0, 1) != 0) ? 2'd0 : 2'd3);
                5: f.pad = $urandom_range(0, 17);
                6: f.abort_at = $urandom_range(0, 41);
                7: f.hdr[55:48] = 8'($urandom_range(0, 255));
                default: ;
            endcase
            run_frame($sformatf("r%0d_k%0d", i, k), f, $urandom_range(4, 10));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
